// File: rtl/ifft8_seq.sv
// Sequential 8-point radix-2 DIT inverse FFT using one time-shared butterfly.
// Define IFFT8_SAT_EN to saturate output components; by default they wrap.
module ifft8_seq #(
    parameter int IN_W  = 4,
    parameter int OUT_W = IN_W + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_re,
    input  logic signed [IN_W-1:0]  in_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic                    out_last
);

    localparam int W = IN_W + 4;
    localparam logic signed [W+9:0] C_P = (W+10)'(181);
    localparam logic signed [W+9:0] C_N = -C_P;

`ifdef IFFT8_SAT_EN
    localparam logic signed [W-1:0] SAT_MAX = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic signed [OUT_W-1:0] out_re_q, out_re_d;
    logic signed [OUT_W-1:0] out_im_q, out_im_d;

    logic signed [W-1:0]     buf_re_q [8];
    logic signed [W-1:0]     buf_im_q [8];

    logic                    load_we, bfly_we;
    logic [2:0]              idx_a, idx_b, load_slot, drain_nxt;
    logic [1:0]              tw;
    logic signed [W-1:0]     a_re, a_im, b_re, b_im, t_re, t_im;
    logic signed [W+9:0]     bx_re, bx_im, p_re, p_im;

    // Divide by 8 (floor), then reduce to the output width.
    function automatic logic signed [OUT_W-1:0] to_out(input logic signed [W-1:0] v);
        logic signed [W-1:0] s;
        s = v >>> 3;
`ifdef IFFT8_SAT_EN
        if (s > SAT_MAX)      return OUT_W'(SAT_MAX);
        else if (s < SAT_MIN) return OUT_W'(SAT_MIN);
        else                  return OUT_W'(s);
`else
        return OUT_W'(s);
`endif
    endfunction

    assign load_slot = {cnt_q[0], cnt_q[1], cnt_q[2]};
    assign drain_nxt = cnt_q[2:0] + 3'd1;

    // cnt_q[3:2] is the stage, cnt_q[1:0] the butterfly within the stage.
    always_comb begin
        idx_a = '0;
        idx_b = '0;
        tw    = '0;
        case (cnt_q[3:2])
            2'd0: begin
                idx_a = {cnt_q[1:0], 1'b0};
                idx_b = {cnt_q[1:0], 1'b1};
            end
            2'd1: begin
                idx_a = {cnt_q[1], 1'b0, cnt_q[0]};
                idx_b = {cnt_q[1], 1'b1, cnt_q[0]};
                tw    = {cnt_q[0], 1'b0};
            end
            2'd2: begin
                idx_a = {1'b0, cnt_q[1:0]};
                idx_b = {1'b1, cnt_q[1:0]};
                tw    = cnt_q[1:0];
            end
            default: ;
        endcase
    end

    assign a_re  = buf_re_q[idx_a];
    assign a_im  = buf_im_q[idx_a];
    assign b_re  = buf_re_q[idx_b];
    assign b_im  = buf_im_q[idx_b];
    assign bx_re = (W+10)'(b_re);
    assign bx_im = (W+10)'(b_im);

    // Twiddle W^-tw applied to b; W^0 and W^-2 are exact, the others use C/256.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        p_re = '0;
        p_im = '0;
        t_re = b_re;
        t_im = b_im;
        case (tw)
            2'd1: begin
                p_re = bx_re * C_P - bx_im * C_P;
                p_im = bx_re * C_P + bx_im * C_P;
                t_re = W'(p_re >>> 8);
                t_im = W'(p_im >>> 8);
            end
            2'd2: begin
                t_re = -b_im;
                t_im = b_re;
            end
            2'd3: begin
                p_re = bx_re * C_N - bx_im * C_P;
                p_im = bx_re * C_P + bx_im * C_N;
                t_re = W'(p_re >>> 8);
                t_im = W'(p_im >>> 8);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        load_we     = 1'b0;
        bfly_we     = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    load_we = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        state_d = CALC;
                        cnt_d   = '0;
                    end
                end
            end
            CALC: begin
                bfly_we = 1'b1;
                cnt_d   = cnt_q + 4'd1;
                // Slot 0 is final after stage 3 butterfly 0, so x[0] can be loaded now.
                if (cnt_q == 4'd11) begin
                    state_d     = DRAIN;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_re_d    = to_out(buf_re_q[0]);
                    out_im_d    = to_out(buf_im_q[0]);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == 4'd7) begin
                        state_d     = LOAD;
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        cnt_d      = cnt_q + 4'd1;
                        out_last_d = (cnt_q == 4'd6);
                        out_re_d   = to_out(buf_re_q[drain_nxt]);
                        out_im_d   = to_out(buf_im_q[drain_nxt]);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
        in_ready_d = (state_d == LOAD);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    // NOTE: the sample buffer has no reset; every slot is rewritten by LOAD before it is read.
    always_ff @(posedge clk) begin
        if (load_we) begin
            buf_re_q[load_slot] <= {{(W-IN_W){in_re[IN_W-1]}}, in_re};
            buf_im_q[load_slot] <= {{(W-IN_W){in_im[IN_W-1]}}, in_im};
        end
        if (bfly_we) begin
            buf_re_q[idx_a] <= a_re + t_re;
            buf_im_q[idx_a] <= a_im + t_im;
            buf_re_q[idx_b] <= a_re - t_re;
            buf_im_q[idx_b] <= a_im - t_im;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

endmodule

// File: tb/tb_ifft8_seq.sv
// Scoreboard bench for ifft8_seq: directed frames push expected samples, a monitor pops them.
module tb_ifft8_seq;

    localparam int IN_W  = 8;
    localparam int OUT_W = 10;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b1;
    logic                    in_ready, out_valid, out_last;
    logic signed [IN_W-1:0]  in_re = '0;
    logic signed [IN_W-1:0]  in_im = '0;
    logic signed [OUT_W-1:0] out_re, out_im;

    typedef struct {
        int re;
        int im;
        int last;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    ifft8_seq #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: each negedge with valid & ready precedes exactly one output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_has_entry", sb_q.size(), 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_re", int'(out_re), e.re);
                check("out_im", int'(out_im), e.im);
                check("out_last", int'(out_last), e.last);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input int xr[8], input int xi[8]);
        for (int k = 0; k < 8; k++) begin
            int g;
            g = 0;
            in_valid = 1'b1;
            in_re    = IN_W'(xr[k]);
            in_im    = IN_W'(xi[k]);
            while (!in_ready && g < 50) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 50) check("in_ready_timeout", g, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int xr[8], input int xi[8], input int er[8], input int ei[8],
                             input bit bp, input bit junk);
        int  lat, n, cyc;
        bit  seen_ready, stalled, moved, stall_ready;
        logic signed [OUT_W-1:0] held_re, held_im;
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.re = er[i];
            e.im = ei[i];
            e.last = (i == 7) ? 1 : 0;
            sb_q.push_back(e);
        end
        send_frame(xr, xi);
        if (junk) begin
            in_valid = 1'b1;
            in_re    = 8'sd5;
            in_im    = -8'sd3;
        end
        lat = 0;
        seen_ready = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            seen_ready |= in_ready;
        end
        check("latency", lat, 12);
        check("in_ready_calc", int'(seen_ready), 0);
        in_valid = 1'b0;

        n = 0;
        cyc = 0;
        seen_ready = 1'b0;
        stalled = 1'b0;
        while (n < 8 && cyc < 100) begin
            if (bp && n == 3 && !stalled) begin
                stalled     = 1'b1;
                out_ready   = 1'b0;
                held_re     = out_re;
                held_im     = out_im;
                moved       = 1'b0;
                stall_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    if (!out_valid || out_re !== held_re || out_im !== held_im) moved = 1'b1;
                    stall_ready |= in_ready;
                end
                check("bp_hold", int'(moved), 0);
                check("bp_in_ready", int'(stall_ready), 0);
                check("bp_x3_re", int'(out_re), er[3]);
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) n++;
            seen_ready |= in_ready;
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_cycles", cyc, 8);
        check("in_ready_drain", int'(seen_ready), 0);
        check("in_ready_after", int'(in_ready), 1);
        check("out_valid_after", int'(out_valid), 0);
    endtask

    initial begin
        int cr[8], ci[8], zr[8], dr[8], der[8], tr[8], ter[8], tei[8];
        int bi[8], ber[8], bei[8], cer[8];
        bit seen_valid;

        cr  = '{7, 7, 7, 7, 7, 7, 7, 7};
        ci  = '{0, 0, 0, 0, 0, 0, 0, 0};
        zr  = '{0, 0, 0, 0, 0, 0, 0, 0};
        cer = '{7, 0, 0, 0, 0, 0, 0, 0};
        dr  = '{-8, 0, 0, 0, 0, 0, 0, 0};
        der = '{-1, -1, -1, -1, -1, -1, -1, -1};
        tr  = '{0, 64, 0, 0, 0, 0, 0, 0};
        ter = '{8, 5, 0, -6, -8, -6, 0, 5};
        tei = '{0, 5, 8, 5, 0, -6, -8, -6};
        bi  = '{0, 0, 32, 0, 0, 0, 0, 0};
        ber = '{0, -4, 0, 4, 0, -4, 0, 4};
        bei = '{4, 0, -4, 0, 4, 0, -4, 0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_re", int'(out_re), 0);
        check("rst_out_im", int'(out_im), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_release", int'(in_ready), 1);

        run_frame(cr, ci, cer, zr, 1'b0, 1'b0);
        run_frame(dr, zr, der, zr, 1'b0, 1'b1);
        run_frame(tr, zr, ter, tei, 1'b0, 1'b0);
        run_frame(zr, bi, ber, bei, 1'b1, 1'b0);

        // Abort a frame during CALC cycle 6; nothing is pushed for it.
        send_frame(cr, ci);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (20) begin
            seen_valid |= out_valid;
            @(posedge clk); #1;
        end
        check("abort_no_output", int'(seen_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        run_frame(cr, ci, cer, zr, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifft8_seq.md
# ifft8_seq

Sequential 8-point radix-2 decimation-in-time inverse FFT. It is the inverse-direction companion to the combinational `fft8`. It accepts one spectrum frame X[0..7] as a stream of signed complex samples, computes x[n] = (1/8)·Σ X[k]·e^{+j2πnk/8} with a single time-shared butterfly, and streams out the time-domain frame x[0..7]. Input and output both use valid/ready handshakes.

## Interface
- `IN_W`, 4, input component width (signed two's complement)
- `OUT_W`, IN_W+2, output component width (signed)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  block can accept an input sample
- `in_re`, `in_im`  in  IN_W  X[k] real and imaginary parts, k = 0..7 in natural order
- `out_valid`  out  1  output sample valid
- `out_ready`  in  1  downstream accepts the output sample
- `out_re`, `out_im`  out  OUT_W  x[n] real and imaginary parts, n = 0..7 in natural order
- `out_last`  out  1  high with x[7]

## Operation
- FSM states: LOAD, CALC, DRAIN. Reset state is LOAD.
- **LOAD**
  - `in_ready` = 1.
  - Each handshake (`in_valid` & `in_ready`) writes sample k into buffer slot bitrev3(k), sign-extended to W = IN_W+4 bits.
  - After the 8th handshake, go to CALC.
- **CALC**
  - One butterfly per cycle; 3 stages × 4 butterflies = 12 cycles.
  - Stage s = 1, 2, 3 pairs slots i and i + 2^(s-1).
  - Butterfly: a' = a + W·b, b' = a − W·b, computed full width W with no per-stage scaling.
- **Twiddles** (inverse sign, C = 181 ≈ 256/√2):
  - W^0 is a pass-through, no multiply.
  - W^-2 = j, implemented exactly: (re, im) → (−im, re).
  - W^-1 = (C, C) and W^-3 = (−C, C). Product re = (br·wr − bi·wi) >>> 8 and im = (br·wi + bi·wr) >>> 8, arithmetic shift (floor).
- **DRAIN**
  - Slot n is presented as x[n]; each component = slot >>> 3 (floor), reduced to OUT_W.
  - Advance on `out_valid` & `out_ready`.
  - After the x[7] handshake, go to LOAD.
- `in_ready` = 0 in CALC and DRAIN. Input frames never overlap output frames.
- `in_valid` is ignored outside LOAD.
- Output data is held stable while `out_valid` & !`out_ready`.

## Timing
- Reset values, registered on the edge where `rst` = 1:
  - `out_valid` = 0, `out_last` = 0, `out_re` = `out_im` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 on the first cycle after.
  - Input count = 0; any partial frame is discarded.
- `rst` in any state, including mid-CALC and mid-DRAIN, aborts the frame. The next frame is processed correctly.
- Latency: if the 8th input is accepted at edge E, CALC occupies edges E+1..E+12 and `out_valid` rises after edge E+12.
- With `out_ready` held at 1, x[0..7] come out on 8 consecutive cycles. `in_ready` rises the cycle after the x[7] handshake.
- Throughput: minimum 8 + 12 + 8 = 28 cycles per frame.
- All outputs are registered. There are no combinational paths from inputs to outputs except `in_ready`, which depends on FSM state only.

## Configuration
- `IFFT8_SAT_EN`
  - Defined: output components saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Undefined: output components wrap, keeping the OUT_W LSBs.
- With the default OUT_W, overflow cannot occur and the two builds are identical.

## Test plan
- **Reset:** `rst` high 2 cycles → `out_valid` = 0, `out_re` = `out_im` = 0, `in_ready` = 0; `in_ready` = 1 on the first cycle after release.
- **Constant spectrum:** X[k] = 7+0j for all k (IN_W = 4) → x[0] = 7+0j, x[1..7] = 0+0j, with `out_last` on x[7]. `out_valid` rises 12 cycles after the 8th input is accepted.
- **DC impulse:** X[0] = −8+0j, others 0 → all x[n] = −1+0j (floor of −8/8).
- **Twiddle path** (IN_W = 8, OUT_W = 10): X[1] = 64+0j, others 0 → expected outputs:
  - x0 = (8, 0), x1 = (5, 5), x2 = (0, 8), x3 = (−6, 5)
  - x4 = (−8, 0), x5 = (−6, −6), x6 = (0, −8), x7 = (5, −6)
- **Backpressure:** hold `out_ready` = 0 for 5 cycles at x[3] → x[3] held stable, `in_ready` = 0 throughout; the frame completes in order once `out_ready` = 1.
- **Reset mid-CALC:** pulse `rst` during cycle 6 of CALC → `out_valid` never rises for that frame. The next frame (the constant-spectrum case) produces the correct result.
